alarm_vote_unit: RTL and testbench
==================================

# alarm_vote_unit

Three-sensor alarm decision block. It evaluates one fixed 3-input alarm function in three independent forms:
- minimized gate-level (structural)
- minimized behavioral
- product-of-sums behavioral

It registers all three results and flags any disagreement between them. It sits between the synchronized sensor inputs and the alarm driver. The redundant forms provide a built-in self-check of the logic.

## Interface
Parameters:
- None. The truth table is fixed by the package constant ALARM_TRUTH = 8'hE8, indexed by {a,b,c}.

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset; synchronous, active-high
- a  input  1  sensor A (MSB of truth-table index)
- b  input  1  sensor B
- c  input  1  sensor C (LSB of truth-table index)
- y_mmz_stl  output  1  registered result of the minimized structural form
- y_mmz_bvl  output  1  registered result of the minimized behavioral form
- y_pos_bvl  output  1  registered result of the product-of-sums behavioral form
- alarm  output  1  registered 2-of-3 vote of the three forms
- mismatch  output  1  registered; 1 when the three forms do not all agree

## Operation
- Alarm function: majority of sensors, Y = 1 when at least two of a, b, c are 1.
  - Minterms 3, 5, 6, 7; maxterms 0, 1, 2, 4.
- Minimized form: Y = a·b + a·c + b·c.
  - Structural variant: built only from 2-input AND gates and one 3-input OR (or an equivalent OR tree) as explicit gate instances.
  - Behavioral variant: a continuous assignment of the same expression.
- POS form: Y = (a+b+c)(a+b+c')(a+b'+c)(a'+b+c), written as a behavioral expression. It is not simplified.
- Combinational results are computed from the current a, b, c and captured into the output registers on each rising clk.
- alarm = majority(y_mmz_stl, y_mmz_bvl, y_pos_bvl), computed from the combinational results and registered in the same cycle.
- mismatch = NOT(all three combinational results equal), registered in the same cycle.
  - In correct hardware, mismatch is always 0.
- No other state. No enable, no handshake.

## Timing
- Latency: exactly 1 clock. Inputs are sampled at edge N; all five outputs reflect them after edge N.
- Reset: when rst = 1 at a rising edge, all outputs become 0 on that edge.
  - This includes y_mmz_stl, y_mmz_bvl, y_pos_bvl, alarm and mismatch.
  - rst has priority over input sampling.
- Reset mid-operation: outputs clear on the reset edge regardless of inputs.
  - The first edge with rst = 0 captures the then-current inputs. No extra recovery cycle.
- Input changes between edges have no effect on outputs until the next edge. No glitches propagate to the outputs.
- All outputs update together. There is no cycle in which the vote or flag lags the individual results.

## Structure
- Shared package alarm_pkg:
  - ALARM_TRUTH = 8'hE8
  - ALARM_IDX_W = 3
  - the reset value constant ALARM_RST = 1'b0
- One sub-module: alarm_mmz_gates.
  - Pure combinational, gate-instance implementation of a·b + a·c + b·c.
  - Ports a, b, c in; y out.
- Behavioral minimized and POS forms, vote, compare and output registers live in the top.
- Verification references the package truth table, not any of the RTL expressions.

## Test plan
- Exhaustive sweep: after reset release, apply {a,b,c} = 000, 001, 010, 011, 100, 101, 110, 111 on successive edges. Each of y_mmz_stl, y_mmz_bvl, y_pos_bvl and alarm must read 0, 0, 0, 1, 0, 1, 1, 1 one cycle after each vector, and mismatch must stay 0 throughout.
- Reset: hold {a,b,c} = 111 with rst = 1 for 2 edges. All outputs must be 0. Deassert rst; after the next edge all four result outputs must be 1.
- Reset mid-stream: during the sweep, assert rst for one edge while {a,b,c} = 110. All outputs must be 0 on that edge, then resume the expected values on the following edge.
- Latency/sampling: toggle c between 0 and 1 mid-cycle with a = 1, b = 0. Outputs must change only at rising edges, showing the value of c present at that edge (0 → 0, 1 → 1).
- Fault cross-check: force the alarm_mmz_gates output to 0 with inputs 111. y_mmz_stl must be 0, alarm must be 1 (2-of-3 vote) and mismatch must be 1 one cycle later. Release the force; mismatch must return to 0 after the next edge.

Source files
------------

// File: rtl/alarm_pkg.sv
//------------------------------------------------------------------------------
// Module  : alarm_pkg
// Brief   : Shared constants and helpers for the three-sensor alarm vote unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alarm_pkg;

    localparam logic [7:0] ALARM_TRUTH = 8'hE8;
    localparam int         ALARM_IDX_W = 3;
    localparam logic       ALARM_RST   = 1'b0;

    function automatic logic majority3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alarm_mmz_gates.sv
//------------------------------------------------------------------------------
// Module  : alarm_mmz_gates
// Brief   : Gate-instance form of the minimized majority function ab + ac + bc.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alarm_mmz_gates (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    wire w_ab;
    wire w_ac;
    wire w_bc;

    and u_and_ab (w_ab, a, b);
    and u_and_ac (w_ac, a, c);
    and u_and_bc (w_bc, b, c);
    or  u_or3    (y, w_ab, w_ac, w_bc);

endmodule

`default_nettype wire

// File: rtl/alarm_vote_unit.sv
//------------------------------------------------------------------------------
// Module  : alarm_vote_unit
// Brief   : Evaluates the alarm function in three redundant forms, registers
//           each result, their 2-of-3 vote and a disagreement flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alarm_vote_unit
    import alarm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y_mmz_stl,
    output logic y_mmz_bvl,
    output logic y_pos_bvl,
    output logic alarm,
    output logic mismatch
);

    logic w_y_mmz_stl;
    logic w_y_mmz_bvl;
    logic w_y_pos_bvl;
    logic w_alarm;
    logic w_mismatch;

    logic r_y_mmz_stl;
    logic r_y_mmz_bvl;
    logic r_y_pos_bvl;
    logic r_alarm;
    logic r_mismatch;

    alarm_mmz_gates u_mmz_gates (
        .a (a),
        .b (b),
        .c (c),
        .y (w_y_mmz_stl)
    );

    assign w_y_mmz_bvl = (a & b) | (a & c) | (b & c);

    // Kept as the unsimplified product of the four maxterms 0, 1, 2, 4.
    assign w_y_pos_bvl = ( a |  b |  c) &
                         ( a |  b | ~c) &
                         ( a | ~b |  c) &
                         (~a |  b |  c);

    assign w_alarm    = majority3(w_y_mmz_stl, w_y_mmz_bvl, w_y_pos_bvl);
    assign w_mismatch = ~((w_y_mmz_stl == w_y_mmz_bvl) && (w_y_mmz_bvl == w_y_pos_bvl));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_mmz_stl <= ALARM_RST;
            r_y_mmz_bvl <= ALARM_RST;
            r_y_pos_bvl <= ALARM_RST;
            r_alarm     <= ALARM_RST;
            r_mismatch  <= ALARM_RST;
        end else begin
            r_y_mmz_stl <= w_y_mmz_stl;
            r_y_mmz_bvl <= w_y_mmz_bvl;
            r_y_pos_bvl <= w_y_pos_bvl;
            r_alarm     <= w_alarm;
            r_mismatch  <= w_mismatch;
        end
    end

    assign y_mmz_stl = r_y_mmz_stl;
    assign y_mmz_bvl = r_y_mmz_bvl;
    assign y_pos_bvl = r_y_pos_bvl;
    assign alarm     = r_alarm;
    assign mismatch  = r_mismatch;

endmodule

`default_nettype wire

// File: tb/tb_alarm_vote_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_alarm_vote_unit
// Brief   : Directed self-checking bench for alarm_vote_unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alarm_vote_unit;
    import alarm_pkg::*;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic c;
    logic y_mmz_stl;
    logic y_mmz_bvl;
    logic y_pos_bvl;
    logic alarm;
    logic mismatch;

    int tests_run;
    int tests_failed;

    logic [7:0] truth;
    logic [4:0] obs;

    alarm_vote_unit dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c         (c),
        .y_mmz_stl (y_mmz_stl),
        .y_mmz_bvl (y_mmz_bvl),
        .y_pos_bvl (y_pos_bvl),
        .alarm     (alarm),
        .mismatch  (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {y_mmz_stl, y_mmz_bvl, y_pos_bvl, alarm, mismatch};

    // Drive inputs, take one rising edge, then settle 1 time unit past it.
    task automatic step(input logic r, input logic [2:0] abc);
        rst = r;
        {a, b, c} = abc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] expect_of(input logic [2:0] abc);
        logic y;
        y = truth[abc];
        return {y, y, y, y, 1'b0};
    endfunction

    task automatic test_reset;
        step(1'b1, 3'b111);
        step(1'b1, 3'b111);
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_hold: got %b expected %b", obs, 5'b00000);
        end
        step(1'b0, 3'b111);
        tests_run++;
        if (obs !== 5'b11110) begin
            tests_failed++;
            $display("FAIL reset_release: got %b expected %b", obs, 5'b11110);
        end
    endtask

    task automatic test_sweep;
        logic [2:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(1'b0, v);
            tests_run++;
            if (obs !== expect_of(v)) begin
                tests_failed++;
                $display("FAIL sweep_%0d: got %b expected %b", i, obs, expect_of(v));
            end
        end
    endtask

    task automatic test_reset_midstream;
        logic [2:0] v;
        for (int i = 0; i < 6; i++) begin
            v = 3'(i);
            step(1'b0, v);
            tests_run++;
            if (obs !== expect_of(v)) begin
                tests_failed++;
                $display("FAIL mid_pre_%0d: got %b expected %b", i, obs, expect_of(v));
            end
        end
        step(1'b1, 3'b110);
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL mid_reset: got %b expected %b", obs, 5'b00000);
        end
        for (int i = 6; i < 8; i++) begin
            v = 3'(i);
            step(1'b0, v);
            tests_run++;
            if (obs !== expect_of(v)) begin
                tests_failed++;
                $display("FAIL mid_post_%0d: got %b expected %b", i, obs, expect_of(v));
            end
        end
    endtask

    // c toggles between edges; only its value at the edge may reach the outputs.
    task automatic test_sampling;
        step(1'b0, 3'b100);
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL samp_c0: got %b expected %b", obs, 5'b00000);
        end
        c = 1'b1;
        #2;
        c = 1'b0;
        #1;
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL samp_glitch_hold: got %b expected %b", obs, 5'b00000);
        end
        #2;
        c = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs !== 5'b11110) begin
            tests_failed++;
            $display("FAIL samp_c1: got %b expected %b", obs, 5'b11110);
        end
        c = 1'b0;
        #2;
        c = 1'b1;
        #2;
        tests_run++;
        if (obs !== 5'b11110) begin
            tests_failed++;
            $display("FAIL samp_mid_hold: got %b expected %b", obs, 5'b11110);
        end
        c = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (obs !== 5'b00000) begin
            tests_failed++;
            $display("FAIL samp_back_c0: got %b expected %b", obs, 5'b00000);
        end
    endtask

    task automatic test_fault;
        force dut.w_y_mmz_stl = 1'b0;
        step(1'b0, 3'b111);
        tests_run++;
        if (obs !== 5'b01111) begin
            tests_failed++;
            $display("FAIL fault_forced: got %b expected %b", obs, 5'b01111);
        end
        release dut.w_y_mmz_stl;
        step(1'b0, 3'b111);
        tests_run++;
        if (obs !== 5'b11110) begin
            tests_failed++;
            $display("FAIL fault_released: got %b expected %b", obs, 5'b11110);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        truth        = ALARM_TRUTH;
        rst          = 1'b1;
        {a, b, c}    = 3'b000;
        #1;
        test_reset();
        step(1'b1, 3'b000);
        test_sweep();
        test_reset_midstream();
        test_sampling();
        test_fault();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
